dcm_spi_regif: RTL and testbench
================================

// Module: dcm_spi_regif
// PURPOSE
//  SPI slave front end of the motor controller. Sits between the external SPI pins and the per-channel register file.
//  Converts mode-3 SPI byte streams into a byte-wide register bus: one command byte, then auto-incrementing data bytes.
//  Command byte: bit7 = write (1) / read (0); bits[6:0] = start byte address.
//  Read data for the following bytes is prefetched from the register file and shifted out on spi_miso.
// PARAMETERS
//  ADDR_W       7   byte address width; 128-byte register space, wraps.
//  SYNC_STAGES  2   synchroniser depth on spi_ss/spi_clk/spi_mosi (>=2).
// PORTS
//  clk           in   1       system clock; SPI half-period >= 4 clk cycles.
//  reset         in   1       asynchronous, active-low reset.
//  spi_ss        in   1       chip select, active low; async to clk.
//  spi_clk       in   1       SPI clock, idles high (mode 3); async to clk.
//  spi_mosi      in   1       master data; sampled on spi_clk rising edge.
//  spi_miso      out  1       slave data; changes after spi_clk falling edge; 0 while ss high.
//  reg_addr      out  ADDR_W  register bus byte address.
//  reg_wdata     out  8       write data, valid with reg_we.
//  reg_we        out  1       one-cycle write strobe.
//  reg_re        out  1       one-cycle read strobe; reg_rdata is valid on the next cycle.
//  reg_rdata     in   8       register file read data (1-cycle latency from reg_re).
//  xfer_active   out  1       high while a framed transaction is in progress.
//  xfer_done     out  1       one-cycle pulse on ss rising edge that ends a transaction of >=1 data byte.
//  xfer_wr       out  1       write flag of the last command; held until the next command.
// BEHAVIOUR
//  - Reset: spi_miso=0, reg_*=0, strobes=0, xfer_active=0, xfer_done=0, xfer_wr=0. State=IDLE. Bit counter=0.
//  - Reset released with ss low: stay in IDLE until ss is seen high. No partial frame is ever decoded.
//  - Synchronise ss/clk/mosi through SPI_SYNC_STAGES flops. Derive sclk_rise, sclk_fall, ss_fall and ss_rise pulses in the clk domain.
//  - States: IDLE -> (ss_fall) CMD -> (8th rise) DATA -> (ss_rise) IDLE.
//    ss_rise in any state forces IDLE.
//  - Bit shifting: on sclk_rise, shift mosi into rx[7:0] MSB-first and increment the 3-bit count. Count 7->0 completes a byte.
//  - CMD byte complete:
//    - latch xfer_wr = rx[7] and addr = rx[6:0];
//    - pulse reg_re with reg_addr = addr on the same cycle;
//    - capture reg_rdata into tx_next one cycle later.
//  - DATA byte complete:
//    - if xfer_wr, pulse reg_we with reg_addr = addr and reg_wdata = rx;
//    - then addr <= addr+1 mod 2^ADDR_W (127 -> 0);
//    - then pulse reg_re for the new addr and refresh tx_next. The reg_re fires the cycle after reg_we, never the same cycle.
//  - MISO:
//    - on the first sclk_fall of a byte (count==0), load tx <= tx_next and drive tx[7];
//    - each later sclk_fall shifts left and drives the next bit;
//    - during the CMD byte, miso drives 0.
//    - Read data for byte k (k>=1) = reg[start+k-1]. Write transactions also return old register contents.
//  - ss_rise mid-byte: partial byte discarded, no reg_we. xfer_done pulses only if >=1 data byte completed.
//  - ss_fall while already in CMD/DATA (glitch without a seen rise) is ignored.
//  - Bus reads/writes occur only in response to SPI; the bus is idle otherwise.
// STRUCTURE
//  - Shared package dcm_pkg: CMD_WR_BIT=7, CMD_ADDR_MSB=6, DCM_ADDR_W=7, SPI_SYNC_STAGES=2, and the state encoding (IDLE/CMD/DATA).
//  - Sub-module dcm_sync: N-stage synchroniser plus rise/fall detect. Three instances: ss, clk, mosi (mosi without edge detect).
//  - Top level holds the FSM, rx/tx shifters, address counter and bus strobes.
// TESTING (100 MHz clk, 50 ns SPI half-period)
//  1. Write 0xC0,0xFA,0x00,0x09,0xC4 -> reg_we at addr 64..67 with data FA,00,09,C4 in order.
//     One xfer_done pulse with xfer_wr=1.
//  2. Preload reg 0..3 = 5A,01,02,03; read 0x00 + 4 dummy bytes -> master receives 00,5A,01,02,03. No reg_we.
//  3. Write 0x80 followed by 129 bytes -> writes at addr 0..127 then 0 (wrap). Exactly 129 reg_we pulses.
//  4. Write 0x85, 0x11, then ss high after 3 bits of the next byte -> one reg_we (addr 5, 0x11). Partial byte dropped.
//  5. Assert reset (low) mid-DATA, release with ss still low -> no strobes until ss goes high and low again.
//     The next frame decodes normally.
//  6. Command byte only (0x80 then ss high) -> one reg_re, no reg_we, no xfer_done.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared constants and state encoding for the DCM SPI register interface.
package dcm_pkg;

  localparam int unsigned CMD_WR_BIT      = 7;
  localparam int unsigned CMD_ADDR_MSB    = 6;
  localparam int unsigned DCM_ADDR_W      = 7;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } dcm_state_e;

endpackage

// File: rtl/dcm_sync.sv
// N-stage synchroniser for an asynchronous SPI pin, with optional rise/fall pulse detect.
module dcm_sync #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0,
  parameter bit          EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe <= {STAGES{RST_VAL}};
    else        pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= RST_VAL;
        else        prev <= q;
      end
      assign rise_c = q & ~prev;
      assign fall_c = ~q & prev;
    end else begin : g_no_edge
      assign rise_c = 1'b0;
      assign fall_c = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dcm_spi_regif.sv
// Mode-3 SPI slave to byte-wide register bus bridge: command byte, then auto-incrementing data.
module dcm_spi_regif
  import dcm_pkg::*;
#(
  parameter int unsigned ADDR_W      = DCM_ADDR_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_ss,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              xfer_active,
  output logic              xfer_done,
  output logic              xfer_wr
);

  logic ss_q, ss_rise_c, ss_fall_c;
  logic sclk_q, sclk_rise_c, sclk_fall_c;
  logic mosi_q, mosi_rise_c, mosi_fall_c;
  logic edges_unused;

  // ss resets low so a frame already in progress at reset release never produces a fall
  dcm_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(spi_ss), .q(ss_q), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
  );
  dcm_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_sync_clk (
    .clk(clk), .reset(reset), .d(spi_clk), .q(sclk_q), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );
  dcm_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_q), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
  );

  assign edges_unused = ss_q ^ sclk_q ^ mosi_rise_c ^ mosi_fall_c;

  dcm_state_e        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx;
  logic [6:0]        tx;
  logic [7:0]        tx_next;
  logic [ADDR_W-1:0] addr;
  logic              data_seen;
  logic              re_pend;
  logic              rd_cap;
  logic [7:0]        rx_shift_c;

  assign rx_shift_c = {rx, mosi_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rx          <= 7'd0;
      tx          <= 7'd0;
      tx_next     <= 8'd0;
      addr        <= '0;
      data_seen   <= 1'b0;
      re_pend     <= 1'b0;
      rd_cap      <= 1'b0;
      spi_miso    <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= 8'd0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      xfer_active <= 1'b0;
      xfer_done   <= 1'b0;
      xfer_wr     <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      xfer_done <= 1'b0;
      rd_cap    <= reg_re;
      if (rd_cap) tx_next <= reg_rdata;
      // prefetch after a data byte is deferred one cycle so it never overlaps the write
      if (re_pend) begin
        reg_re   <= 1'b1;
        reg_addr <= addr;
        re_pend  <= 1'b0;
      end

      if (ss_rise_c) begin
        state       <= ST_IDLE;
        bit_cnt     <= 3'd0;
        spi_miso    <= 1'b0;
        xfer_active <= 1'b0;
        xfer_done   <= data_seen;
        data_seen   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_fall_c) begin
              state       <= ST_CMD;
              bit_cnt     <= 3'd0;
              spi_miso    <= 1'b0;
              xfer_active <= 1'b1;
            end
          end
          ST_CMD: begin
            if (sclk_fall_c) spi_miso <= 1'b0;
            if (sclk_rise_c) begin
              rx      <= rx_shift_c[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                xfer_wr  <= rx_shift_c[CMD_WR_BIT];
                addr     <= ADDR_W'(rx_shift_c[CMD_ADDR_MSB:0]);
                reg_addr <= ADDR_W'(rx_shift_c[CMD_ADDR_MSB:0]);
                reg_re   <= 1'b1;
                state    <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_fall_c) begin
              if (bit_cnt == 3'd0) begin
                spi_miso <= tx_next[7];
                tx       <= tx_next[6:0];
              end else begin
                spi_miso <= tx[6];
                tx       <= {tx[5:0], 1'b0};
              end
            end
            if (sclk_rise_c) begin
              rx      <= rx_shift_c[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_seen <= 1'b1;
                if (xfer_wr) begin
                  reg_we    <= 1'b1;
                  reg_addr  <= addr;
                  reg_wdata <= rx_shift_c;
                end
                addr    <= addr + ADDR_W'(1);
                re_pend <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcm_spi_regif.sv
// Bench for dcm_spi_regif: SPI master driver, register file, and array-based transaction model.
module tb_dcm_spi_regif;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       spi_ss = 1'b1;
  logic       spi_clk = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata;
  logic       xfer_active, xfer_done, xfer_wr;

  always #5 clk = ~clk;

  dcm_spi_regif dut (
    .clk(clk), .reset(reset), .spi_ss(spi_ss), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .xfer_active(xfer_active),
    .xfer_done(xfer_done), .xfer_wr(xfer_wr)
  );

  // register file with one-cycle read latency
  bit [7:0] mem [128];
  bit [7:0] rdata_q;
  assign reg_rdata = rdata_q;
  always @(posedge clk) begin
    if (reg_re) rdata_q <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // bus monitor, sampled on the falling edge
  int       re_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  bit [6:0] we_addr_q[$];
  bit [7:0] we_data_q[$];
  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_cnt++;
    if (xfer_done) done_cnt++;
    if (reg_we && reg_re) overlap_cnt++;
  end

  int       tests = 0, fails = 0;
  bit [7:0] shadow [128];
  bit [7:0] mtx [300];
  bit [7:0] mrx [300];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input bit [7:0] b, input int nbits, output bit [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_clk  = 1'b0;
      spi_mosi = b[i];
      #50;
      r[i]    = spi_miso;
      spi_clk = 1'b1;
      #50;
    end
  endtask

  // one framed transaction: mtx[0] = command, mtx[1..n] = data, then extra bits of a partial byte
  task automatic run_frame(input int n, input int extra);
    bit [7:0] dummy;
    bit       wr;
    int       start, re_base, done_base, we_base;
    bit [7:0] exp_rx [300];
    bit [6:0] exp_a [$];
    bit [7:0] exp_d [$];
    wr        = mtx[0][7];
    start     = int'(mtx[0][6:0]);
    re_base   = re_cnt;
    done_base = done_cnt;
    we_base   = we_addr_q.size();
    exp_rx[0] = 8'h00;
    for (int k = 1; k <= n; k++) begin
      exp_rx[k] = shadow[(start + k - 1) % 128];
      if (wr) begin
        shadow[(start + k - 1) % 128] = mtx[k];
        exp_a.push_back(7'((start + k - 1) % 128));
        exp_d.push_back(mtx[k]);
      end
    end
    spi_ss = 1'b0;
    #100;
    check("xfer_active_in_frame", 32'(xfer_active), 32'd1);
    for (int k = 0; k <= n; k++) spi_byte(mtx[k], 8, mrx[k]);
    if (extra > 0) spi_byte(8'($urandom), extra, dummy);
    #100;
    spi_ss = 1'b1;
    #300;
    for (int k = 0; k <= n; k++) check($sformatf("miso_byte%0d", k), 32'(mrx[k]), 32'(exp_rx[k]));
    check("we_count", 32'(we_addr_q.size() - we_base), 32'(exp_a.size()));
    for (int j = 0; j < exp_a.size() && we_base + j < we_addr_q.size(); j++) begin
      check($sformatf("we_addr%0d", j), 32'(we_addr_q[we_base + j]), 32'(exp_a[j]));
      check($sformatf("we_data%0d", j), 32'(we_data_q[we_base + j]), 32'(exp_d[j]));
    end
    check("re_count", 32'(re_cnt - re_base), 32'(1 + n));
    check("done_count", 32'(done_cnt - done_base), (n >= 1) ? 32'd1 : 32'd0);
    check("xfer_wr", 32'(xfer_wr), 32'(wr));
    check("xfer_active_idle", 32'(xfer_active), 32'd0);
  endtask

  initial begin
    bit [7:0] junk;
    int       re_base, done_base, we_base;
    #23;
    check("reset_outputs", 32'({spi_miso, reg_addr, reg_wdata, reg_we, reg_re,
                                xfer_active, xfer_done, xfer_wr}), 32'd0);
    reset = 1'b1;
    #200;

    // directed write of four bytes at 64
    mtx[0] = 8'hC0; mtx[1] = 8'hFA; mtx[2] = 8'h00; mtx[3] = 8'h09; mtx[4] = 8'hC4;
    run_frame(4, 0);

    // preload 0..3 then read them back
    mtx[0] = 8'h80; mtx[1] = 8'h5A; mtx[2] = 8'h01; mtx[3] = 8'h02; mtx[4] = 8'h03;
    run_frame(4, 0);
    mtx[0] = 8'h00;
    for (int k = 1; k <= 4; k++) mtx[k] = 8'($urandom);
    run_frame(4, 0);
    check("read_byte1_5A", 32'(mrx[1]), 32'h5A);

    // 129 writes from 0, wrapping back to 0
    mtx[0] = 8'h80;
    for (int k = 1; k <= 129; k++) mtx[k] = 8'($urandom);
    run_frame(129, 0);

    // partial byte after one complete data byte
    mtx[0] = 8'h85; mtx[1] = 8'h11;
    run_frame(1, 3);

    // reset mid-data with ss held low
    spi_ss = 1'b0;
    #100;
    spi_byte(8'h90, 8, junk);
    spi_byte(8'h77, 4, junk);
    reset = 1'b0;
    #40;
    reset = 1'b1;
    #100;
    re_base   = re_cnt;
    done_base = done_cnt;
    we_base   = we_addr_q.size();
    spi_byte(8'h81, 8, junk);
    spi_byte(8'h33, 8, junk);
    check("post_reset_idle", 32'(xfer_active), 32'd0);
    #100;
    spi_ss = 1'b1;
    #300;
    check("post_reset_re", 32'(re_cnt - re_base), 32'd0);
    check("post_reset_we", 32'(we_addr_q.size() - we_base), 32'd0);
    check("post_reset_done", 32'(done_cnt - done_base), 32'd0);
    mtx[0] = 8'hA0; mtx[1] = 8'h3C; mtx[2] = 8'hC3;
    run_frame(2, 0);

    // command byte only
    mtx[0] = 8'h80;
    run_frame(0, 0);

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      int n;
      n = int'($urandom_range(0, 6));
      mtx[0] = 8'($urandom);
      for (int k = 1; k <= n; k++) mtx[k] = 8'($urandom);
      run_frame(n, int'($urandom_range(0, 7)));
    end

    check("we_re_overlap", 32'(overlap_cnt), 32'd0);
    for (int a = 0; a < 128; a++) check($sformatf("mem%0d", a), 32'(mem[a]), 32'(shadow[a]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
